axis_eth_tx_arb: RTL

Frame-granular round-robin arbiter that merges S_COUNT 8-bit AXI-Stream Ethernet transmit sources into one stream feeding the FCS inserter. A grant is held from the first beat to the tlast beat of a frame, so frames never interleave. The arbiter never splits, reorders or alters frame bytes. A registered skid-buffered output stage decouples downstream backpressure, and optional inter-frame idle cycles can be inserted.

---
 rtl/axis_eth_tx_arb_if.sv | 30 +++
 rtl/axis_eth_tx_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_eth_tx_arb_if.sv
// AXI-Stream byte bus bundle for axis_eth_tx_arb.
// N lanes of 8-bit data with per-lane valid/ready/last/user.
// Lane i data lives in tdata[8i+7:8i].
interface axis_eth_tx_arb_if #(
  parameter int unsigned N = 1
);

  logic [N*8-1:0] tdata;
  logic [N-1:0]   tvalid;
  logic [N-1:0]   tready;
  logic [N-1:0]   tlast;
  logic [N-1:0]   tuser;

  modport master (
    output tdata,
    output tvalid,
    output tlast,
    output tuser,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    input  tlast,
    input  tuser,
    output tready
  );

endinterface

// File: rtl/axis_eth_tx_arb.sv
// axis_eth_tx_arb: frame-granular round-robin merge of S_COUNT 8-bit
// AXI-Stream transmit sources into one stream. A grant is held from the
// first beat to the tlast beat, so frames never interleave. A registered
// output stage with a one-entry skid register isolates downstream backpressure.
// Optional inter-frame gap: define AXIS_ETH_TX_ARB_IFG_EN to build the GAP
// state and counter (IFG_CYCLES idle cycles after each frame).
module axis_eth_tx_arb #(
  parameter int unsigned S_COUNT    = 4,
  parameter int unsigned IFG_CYCLES = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  axis_eth_tx_arb_if.slave        s_axis,
  axis_eth_tx_arb_if.master       m_axis,
  output logic                    grant_valid,
  output logic [((S_COUNT > 1) ? $clog2(S_COUNT) : 1)-1:0] grant_index,
  output logic                    busy
);

  localparam int unsigned IW = (S_COUNT > 1) ? $clog2(S_COUNT) : 1;

  // Parameter range guards
  if ((S_COUNT == 0) || (S_COUNT > 16)) begin : g_bad_s_count
    $error("axis_eth_tx_arb: S_COUNT must be 1..16");
  end
  if (IFG_CYCLES > 255) begin : g_bad_ifg
    $error("axis_eth_tx_arb: IFG_CYCLES must be 0..255");
  end

`ifdef AXIS_ETH_TX_ARB_IFG_EN
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_GAP    = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1
  } state_t;
`endif

  // Arbitration state
  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_grant_index;
  logic [IW-1:0]   w_grant_index_nxt;
  logic            r_grant_valid;
  logic            w_grant_valid_nxt;
  logic [IW-1:0]   r_last_grant;
  logic [IW-1:0]   w_last_grant_nxt;
  logic            r_busy;
`ifdef AXIS_ETH_TX_ARB_IFG_EN
  logic [7:0]      r_ifg_cnt;
  logic [7:0]      w_ifg_cnt_nxt;
`endif

  // Granted-source mux and round-robin search
  logic            w_sel_tvalid;
  logic [7:0]      w_sel_tdata;
  logic            w_sel_tlast;
  logic            w_sel_tuser;
  logic [IW-1:0]   w_rr_hi;
  logic [IW-1:0]   w_rr_lo;
  logic            w_rr_hi_found;
  logic [IW-1:0]   w_rr_index;
  logic            w_accept;
  logic [S_COUNT-1:0] w_s_tready;

  // Output stage (output register + skid register)
  logic            r_int_ready;
  logic            w_ready_early;
  logic [7:0]      r_m_tdata;
  logic            r_m_tvalid;
  logic            r_m_tlast;
  logic            r_m_tuser;
  logic [7:0]      r_tmp_tdata;
  logic            r_tmp_tvalid;
  logic            r_tmp_tlast;
  logic            r_tmp_tuser;
  logic            w_m_tvalid_nxt;
  logic            w_tmp_tvalid_nxt;
  logic            w_store_int_to_out;
  logic            w_store_int_to_tmp;
  logic            w_store_tmp_to_out;

  // Select the granted source's beat
  always_comb begin
    w_sel_tvalid = 1'b0;
    w_sel_tdata  = '0;
    w_sel_tlast  = 1'b0;
    w_sel_tuser  = 1'b0;
    for (int i = 0; i < int'(S_COUNT); i++) begin
      if (r_grant_index == IW'(i)) begin
        w_sel_tvalid = s_axis.tvalid[i];
        w_sel_tdata  = s_axis.tdata[8*i +: 8];
        w_sel_tlast  = s_axis.tlast[i];
        w_sel_tuser  = s_axis.tuser[i];
      end
    end
  end

  // Round-robin: lowest requester above last_grant, else lowest requester overall
  always_comb begin
    w_rr_hi       = '0;
    w_rr_lo       = '0;
    w_rr_hi_found = 1'b0;
    for (int i = int'(S_COUNT) - 1; i >= 0; i--) begin
      if (s_axis.tvalid[i]) begin
        w_rr_lo = IW'(i);
        if (IW'(i) > r_last_grant) begin
          w_rr_hi       = IW'(i);
          w_rr_hi_found = 1'b1;
        end
      end
    end
    w_rr_index = w_rr_hi_found ? w_rr_hi : w_rr_lo;
  end

  // A beat is taken only from the owner while the output stage can absorb it
  assign w_accept = (r_state == S_ACTIVE) && w_sel_tvalid && r_int_ready;

  // Per-source ready: only the owner sees the internal ready
  always_comb begin
    w_s_tready = '0;
    for (int i = 0; i < int'(S_COUNT); i++) begin
      w_s_tready[i] = (r_state == S_ACTIVE) && r_int_ready && (r_grant_index == IW'(i));
    end
  end

  // FSM next-state and grant bookkeeping
  always_comb begin
    w_state_nxt       = r_state;
    w_grant_index_nxt = r_grant_index;
    w_grant_valid_nxt = r_grant_valid;
    w_last_grant_nxt  = r_last_grant;
`ifdef AXIS_ETH_TX_ARB_IFG_EN
    w_ifg_cnt_nxt     = r_ifg_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (|s_axis.tvalid) begin
          w_grant_index_nxt = w_rr_index;
          w_grant_valid_nxt = 1'b1;
          w_state_nxt       = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (w_accept && w_sel_tlast) begin
          w_last_grant_nxt  = r_grant_index;
          w_grant_valid_nxt = 1'b0;
          w_state_nxt       = S_IDLE;
`ifdef AXIS_ETH_TX_ARB_IFG_EN
          if (IFG_CYCLES != 0) begin
            w_state_nxt   = S_GAP;
            w_ifg_cnt_nxt = 8'(IFG_CYCLES - 1);
          end
`endif
        end
      end
`ifdef AXIS_ETH_TX_ARB_IFG_EN
      S_GAP: begin
        if (r_ifg_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_ifg_cnt_nxt = r_ifg_cnt - 8'd1;
        end
      end
`endif
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM and grant registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant_index <= '0;
      r_grant_valid <= 1'b0;
      r_last_grant  <= IW'(S_COUNT - 1);
      r_busy        <= 1'b0;
`ifdef AXIS_ETH_TX_ARB_IFG_EN
      r_ifg_cnt     <= 8'd0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_grant_index <= w_grant_index_nxt;
      r_grant_valid <= w_grant_valid_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
`ifdef AXIS_ETH_TX_ARB_IFG_EN
      r_ifg_cnt     <= w_ifg_cnt_nxt;
`endif
    end
  end

  // Skid control: route incoming beat to output or temp, or drain temp
  always_comb begin
    w_ready_early      = m_axis.tready || (!r_tmp_tvalid && (!r_m_tvalid || !w_accept));
    w_m_tvalid_nxt     = r_m_tvalid;
    w_tmp_tvalid_nxt   = r_tmp_tvalid;
    w_store_int_to_out = 1'b0;
    w_store_int_to_tmp = 1'b0;
    w_store_tmp_to_out = 1'b0;
    if (r_int_ready) begin
      if (m_axis.tready || !r_m_tvalid) begin
        w_m_tvalid_nxt     = w_accept;
        w_store_int_to_out = 1'b1;
      end else begin
        w_tmp_tvalid_nxt   = w_accept;
        w_store_int_to_tmp = 1'b1;
      end
    end else if (m_axis.tready) begin
      w_m_tvalid_nxt     = r_tmp_tvalid;
      w_tmp_tvalid_nxt   = 1'b0;
      w_store_tmp_to_out = 1'b1;
    end
  end

  // Output and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_ready  <= 1'b0;
      r_m_tvalid   <= 1'b0;
      r_m_tdata    <= 8'd0;
      r_m_tlast    <= 1'b0;
      r_m_tuser    <= 1'b0;
      r_tmp_tvalid <= 1'b0;
      r_tmp_tdata  <= 8'd0;
      r_tmp_tlast  <= 1'b0;
      r_tmp_tuser  <= 1'b0;
    end else begin
      r_int_ready  <= w_ready_early;
      r_m_tvalid   <= w_m_tvalid_nxt;
      r_tmp_tvalid <= w_tmp_tvalid_nxt;
      if (w_store_int_to_out) begin
        r_m_tdata <= w_sel_tdata;
        r_m_tlast <= w_sel_tlast;
        r_m_tuser <= w_sel_tuser;
      end else if (w_store_tmp_to_out) begin
        r_m_tdata <= r_tmp_tdata;
        r_m_tlast <= r_tmp_tlast;
        r_m_tuser <= r_tmp_tuser;
      end
      if (w_store_int_to_tmp) begin
        r_tmp_tdata <= w_sel_tdata;
        r_tmp_tlast <= w_sel_tlast;
        r_tmp_tuser <= w_sel_tuser;
      end
    end
  end

  assign s_axis.tready = w_s_tready;
  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tlast  = r_m_tlast;
  assign m_axis.tuser  = r_m_tuser;
  assign grant_valid   = r_grant_valid;
  assign grant_index   = r_grant_index;
  assign busy          = r_busy;

endmodule
